// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite encodings used by the interconnect blocks.
//   htrans_t : transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_t : burst type
//   hresp_t  : slave response (OKAY/ERROR)
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

endpackage

// File: rtl/ahb3lite_interconnect_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb3lite_interconnect_rr_arbiter
// Combinational arbiter: keeps only requesters at the highest requested
// priority, then picks the first of those scanning from last+1 with wrap.
//   req      in  [MASTERS]        request per master port
//   prio     in  [MASTERS][3]     priority per master port, 7 = highest
//   last     in  [IDX_W]          index of the most recent winner
//   next_idx out [IDX_W]          winner (equals last when nothing requests)
//   any_req  out                  at least one request is present
// ---------------------------------------------------------------------------
module ahb3lite_interconnect_rr_arbiter #(
    parameter int MASTERS = 3,
    parameter int IDX_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0] req,
    input  logic [2:0]         prio [MASTERS],
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   next_idx,
    output logic               any_req
);

    logic [2:0] pmax;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        logic [IDX_W-1:0] kk;
        logic             found;
        int               k;

        pmax     = '0;
        next_idx = last;
        found    = 1'b0;
        kk       = '0;

        for (int i = 0; i < MASTERS; i++) begin
            kk = IDX_W'(i);
            if (req[kk] && (prio[kk] > pmax)) begin
                pmax = prio[kk];
            end
        end

        // Rotating start point gives round-robin among equal priorities.
        for (int i = 0; i < MASTERS; i++) begin
            k  = (int'(last) + 1 + i) % MASTERS;
            kk = IDX_W'(k);
            if (!found && req[kk] && (prio[kk] == pmax)) begin
                next_idx = kk;
                found    = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ahb3lite_interconnect_slave_port.sv
// ---------------------------------------------------------------------------
// ahb3lite_interconnect_slave_port
// Slave side of the AHB3-Lite multi-layer switch (one instance per slave).
// Arbitrates master-port connection requests, muxes the owner's address
// phase and the data-phase owner's write data onto the slave bus, and
// broadcasts the slave response back to all master ports.
//   HCLK, HRESETn                     clock, async active-low reset
//   mstpriority/mstHSEL/mstH*         per-master-port request and bus signals
//   mstHREADY                         per-master-port bus ready
//   can_switch                        owner may release the slave
//   master_granted                    registered one-hot grant
//   mstHRDATA/mstHREADYOUT/mstHRESP   slave response, broadcast
//   HSEL..HMASTLOCK, HREADYOUT        AHB slave bus outputs
//   HRDATA, HREADY, HRESP             AHB slave bus inputs
// ---------------------------------------------------------------------------
module ahb3lite_interconnect_slave_port
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic [2:0]            mstpriority  [MASTERS],
    input  logic [MASTERS-1:0]    mstHSEL,
    input  logic [HADDR_SIZE-1:0] mstHADDR     [MASTERS],
    input  logic [HDATA_SIZE-1:0] mstHWDATA    [MASTERS],
    input  logic [MASTERS-1:0]    mstHWRITE,
    input  logic [2:0]            mstHSIZE     [MASTERS],
    input  logic [2:0]            mstHBURST    [MASTERS],
    input  logic [3:0]            mstHPROT     [MASTERS],
    input  logic [1:0]            mstHTRANS    [MASTERS],
    input  logic [MASTERS-1:0]    mstHMASTLOCK,
    input  logic [MASTERS-1:0]    mstHREADY,
    input  logic [MASTERS-1:0]    can_switch,
    output logic [MASTERS-1:0]    master_granted,

    output logic [HDATA_SIZE-1:0] mstHRDATA,
    output logic                  mstHREADYOUT,
    output logic                  mstHRESP,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic                  HREADYOUT,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] grant_q,  grant_d;
    logic [IDX_W-1:0]   last_q,   last_d;
    logic [IDX_W-1:0]   dp_sel_q, dp_sel_d;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   own;
    logic               any_req;
    logic               switch_ok;

    // The round-robin pointer always records the current winner, so it
    // doubles as the address-phase owner index.
    assign own = last_q;

    ahb3lite_interconnect_rr_arbiter #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req      (mstHSEL),
        .prio     (mstpriority),
        .last     (last_q),
        .next_idx (next_idx),
        .any_req  (any_req)
    );

    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        dp_sel_d = dp_sel_q;

        // An idle owner releases the slave unless it still asserts a lock.
        switch_ok = HREADY && (can_switch[own] ||
                               (!mstHSEL[own] && !mstHMASTLOCK[own]));

        if (switch_ok && any_req) begin
            grant_d           = '0;
            grant_d[next_idx] = 1'b1;
            last_d            = next_idx;
        end

        // Address phase completing now becomes the next data phase.
        if (HREADY) begin
            dp_sel_d = own;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= MASTERS'(1);
            last_q   <= '0;
            dp_sel_q <= '0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            dp_sel_q <= dp_sel_d;
        end
    end

    assign master_granted = grant_q;

    // Address phase from the granted master port.
    assign HSEL      = mstHSEL[own];
    assign HADDR     = mstHADDR[own];
    assign HWRITE    = mstHWRITE[own];
    assign HSIZE     = mstHSIZE[own];
    assign HBURST    = mstHBURST[own];
    assign HPROT     = mstHPROT[own];
    assign HMASTLOCK = mstHMASTLOCK[own];
    assign HTRANS    = mstHSEL[own] ? mstHTRANS[own] : HTRANS_IDLE;
    assign HREADYOUT = mstHREADY[own];

    // Data phase from the previous address-phase owner.
    assign HWDATA = mstHWDATA[dp_sel_q];

    // Response broadcast; the data-phase owner consumes it.
    assign mstHRDATA    = HRDATA;
    assign mstHREADYOUT = HREADY;
    assign mstHRESP     = HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
module tb_ahb3lite_interconnect_slave_port;

    localparam int M = 3;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    always #5 HCLK = ~HCLK;

    logic [2:0]  mstpriority  [M];
    logic [M-1:0] mstHSEL;
    logic [31:0] mstHADDR     [M];
    logic [31:0] mstHWDATA    [M];
    logic [M-1:0] mstHWRITE;
    logic [2:0]  mstHSIZE     [M];
    logic [2:0]  mstHBURST    [M];
    logic [3:0]  mstHPROT     [M];
    logic [1:0]  mstHTRANS    [M];
    logic [M-1:0] mstHMASTLOCK;
    logic [M-1:0] mstHREADY;
    logic [M-1:0] can_switch;
    logic [M-1:0] master_granted;
    logic [31:0] mstHRDATA;
    logic        mstHREADYOUT, mstHRESP;
    logic        HSEL, HWRITE, HMASTLOCK, HREADYOUT;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY, HRESP;

    ahb3lite_interconnect_slave_port #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(M)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR),
        .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
        .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
        .can_switch(can_switch), .master_granted(master_granted),
        .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Single-master instance: grant must stay parked on master 0.
    logic [2:0]  s_prio  [1];
    logic [0:0]  s_hsel;
    logic [31:0] s_haddr [1];
    logic [31:0] s_hwdata[1];
    logic [2:0]  s_hsize [1];
    logic [2:0]  s_hburst[1];
    logic [3:0]  s_hprot [1];
    logic [1:0]  s_htrans[1];
    logic [0:0]  s_grant;
    logic [31:0] s_rdata, s_HADDR, s_HWDATA;
    logic        s_readyout, s_resp, s_HSEL, s_HWRITE, s_HMASTLOCK, s_HREADYOUT;
    logic [2:0]  s_HSIZE, s_HBURST;
    logic [3:0]  s_HPROT;
    logic [1:0]  s_HTRANS;

    ahb3lite_interconnect_slave_port #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(1)
    ) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mstpriority(s_prio), .mstHSEL(s_hsel), .mstHADDR(s_haddr),
        .mstHWDATA(s_hwdata), .mstHWRITE(1'b1), .mstHSIZE(s_hsize),
        .mstHBURST(s_hburst), .mstHPROT(s_hprot), .mstHTRANS(s_htrans),
        .mstHMASTLOCK(1'b0), .mstHREADY(1'b1), .can_switch(1'b1),
        .master_granted(s_grant),
        .mstHRDATA(s_rdata), .mstHREADYOUT(s_readyout), .mstHRESP(s_resp),
        .HSEL(s_HSEL), .HADDR(s_HADDR), .HWDATA(s_HWDATA), .HWRITE(s_HWRITE),
        .HSIZE(s_HSIZE), .HBURST(s_HBURST), .HPROT(s_HPROT), .HTRANS(s_HTRANS),
        .HMASTLOCK(s_HMASTLOCK), .HREADYOUT(s_HREADYOUT),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] p2, p1, p0;
        logic [2:0] cs;
        logic [2:0] lock;
        logic       hready;
        logic       hresp;
        logic [2:0] exp_grant;
        logic       exp_hsel;
        logic [1:0] exp_own;
        logic [1:0] exp_dp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int tests  = 0;
    int failed = 0;

    logic [2:0] mst_ready_cfg;
    logic [2:0] mst_write_cfg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [2:0] req, input logic [2:0] p2, input logic [2:0] p1,
        input logic [2:0] p0, input logic [2:0] cs, input logic [2:0] lock,
        input logic hready, input logic hresp, input logic [2:0] eg,
        input logic eh, input logic [1:0] eo, input logic [1:0] ed);
        vec_t v;
        v.req = req; v.p2 = p2; v.p1 = p1; v.p0 = p0; v.cs = cs; v.lock = lock;
        v.hready = hready; v.hresp = hresp; v.exp_grant = eg; v.exp_hsel = eh;
        v.exp_own = eo; v.exp_dp = ed;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        mstHSEL        = v.req;
        mstpriority[0] = v.p0;
        mstpriority[1] = v.p1;
        mstpriority[2] = v.p2;
        can_switch     = v.cs;
        mstHMASTLOCK   = v.lock;
        HREADY         = v.hready;
        HRESP          = v.hresp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        mst_ready_cfg = 3'b101;
        mst_write_cfg = 3'b010;
        for (int i = 0; i < M; i++) begin
            mstHADDR[i]    = 32'hA000_0000 + i;
            mstHWDATA[i]   = 32'hD000_0000 + i;
            mstHSIZE[i]    = 3'b010;
            mstHBURST[i]   = (i == 0) ? 3'b011 : 3'b000;
            mstHPROT[i]    = 4'b0011;
            mstHTRANS[i]   = 2'b10;
            mstpriority[i] = 3'd0;
        end
        mstHWRITE    = mst_write_cfg;
        mstHREADY    = mst_ready_cfg;
        mstHSEL      = '0;
        mstHMASTLOCK = '0;
        can_switch   = '1;
        HREADY       = 1'b1;
        HRESP        = 1'b0;
        HRDATA       = '0;
        s_prio[0] = 3'd0; s_hsel = 1'b0; s_haddr[0] = 32'h5555_0000;
        s_hwdata[0] = 32'h6666_0000; s_hsize[0] = 3'b010; s_hburst[0] = 3'b000;
        s_hprot[0] = 4'b0011; s_htrans[0] = 2'b10;

        //        req     p2 p1 p0 cs      lock   rdy rsp grant   hsel own dp
        vecs[0]  = mk(3'b110, 5, 2, 0, 3'b111, 3'b000, 1, 0, 3'b001, 0, 0, 0);
        vecs[1]  = mk(3'b100, 5, 2, 0, 3'b111, 3'b000, 1, 0, 3'b100, 1, 2, 0);
        vecs[2]  = mk(3'b000, 5, 2, 0, 3'b111, 3'b000, 1, 0, 3'b100, 0, 2, 2);
        vecs[3]  = mk(3'b111, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b100, 1, 2, 2);
        vecs[4]  = mk(3'b111, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b001, 1, 0, 2);
        vecs[5]  = mk(3'b111, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b010, 1, 1, 0);
        vecs[6]  = mk(3'b111, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b100, 1, 2, 1);
        vecs[7]  = mk(3'b000, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b001, 0, 0, 2);
        vecs[8]  = mk(3'b011, 3, 7, 3, 3'b000, 3'b001, 1, 0, 3'b001, 1, 0, 0);
        vecs[9]  = mk(3'b011, 3, 7, 3, 3'b000, 3'b001, 1, 0, 3'b001, 1, 0, 0);
        vecs[10] = mk(3'b011, 3, 7, 3, 3'b001, 3'b001, 1, 0, 3'b001, 1, 0, 0);
        vecs[11] = mk(3'b010, 3, 7, 3, 3'b000, 3'b000, 1, 0, 3'b010, 1, 1, 0);
        vecs[12] = mk(3'b110, 3, 3, 3, 3'b111, 3'b000, 0, 0, 3'b010, 1, 1, 1);
        vecs[13] = mk(3'b110, 3, 3, 3, 3'b111, 3'b000, 0, 0, 3'b010, 1, 1, 1);
        vecs[14] = mk(3'b110, 3, 3, 3, 3'b111, 3'b000, 0, 0, 3'b010, 1, 1, 1);
        vecs[15] = mk(3'b110, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b010, 1, 1, 1);
        vecs[16] = mk(3'b100, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b100, 1, 2, 1);
        vecs[17] = mk(3'b101, 3, 3, 3, 3'b111, 3'b000, 0, 1, 3'b100, 1, 2, 2);
        vecs[18] = mk(3'b101, 3, 3, 3, 3'b111, 3'b000, 1, 1, 3'b100, 1, 2, 2);
        vecs[19] = mk(3'b000, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b001, 0, 0, 2);
        vecs[20] = mk(3'b000, 3, 3, 3, 3'b111, 3'b000, 1, 0, 3'b001, 0, 0, 0);

        // Reset state.
        HRESETn = 1'b0;
        #12;
        check("reset grant",  64'(master_granted), 64'(3'b001));
        check("reset HSEL",   64'(HSEL),   64'(1'b0));
        check("reset HTRANS", 64'(HTRANS), 64'(2'b00));
        check("reset HWDATA", 64'(HWDATA), 64'(32'hD000_0000));
        check("reset m1 grant", 64'(s_grant), 64'(1'b1));
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Table-driven sequence; state carries from one vector to the next.
        for (int n = 0; n < NV; n++) begin
            logic [1:0] o;
            logic [1:0] d;
            @(negedge HCLK);
            apply(vecs[n]);
            HRDATA = 32'hCAFE_0000 + n;
            #1;
            o = vecs[n].exp_own;
            d = vecs[n].exp_dp;
            check($sformatf("v%0d grant", n), 64'(master_granted), 64'(vecs[n].exp_grant));
            check($sformatf("v%0d HSEL", n), 64'(HSEL), 64'(vecs[n].exp_hsel));
            check($sformatf("v%0d HTRANS", n), 64'(HTRANS),
                  64'(vecs[n].exp_hsel ? 2'b10 : 2'b00));
            check($sformatf("v%0d HADDR", n), 64'(HADDR), 64'(32'hA000_0000 + o));
            check($sformatf("v%0d HWDATA", n), 64'(HWDATA), 64'(32'hD000_0000 + d));
            check($sformatf("v%0d HREADYOUT", n), 64'(HREADYOUT), 64'(mst_ready_cfg[o]));
            check($sformatf("v%0d HWRITE", n), 64'(HWRITE), 64'(mst_write_cfg[o]));
            check($sformatf("v%0d HMASTLOCK", n), 64'(HMASTLOCK), 64'(vecs[n].lock[o]));
            check($sformatf("v%0d mstHRDATA", n), 64'(mstHRDATA), 64'(32'hCAFE_0000 + n));
            check($sformatf("v%0d mstHREADYOUT", n), 64'(mstHREADYOUT), 64'(vecs[n].hready));
            check($sformatf("v%0d mstHRESP", n), 64'(mstHRESP), 64'(vecs[n].hresp));
        end

        // Reset in the middle of an M2 transfer returns to the parked state.
        @(negedge HCLK);
        mstHSEL = 3'b100; can_switch = 3'b111; HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        check("pre-reset grant",  64'(master_granted), 64'(3'b100));
        check("pre-reset HWDATA", 64'(HWDATA), 64'(32'hD000_0002));
        #2;
        HRESETn = 1'b0;
        #1;
        check("async reset grant",  64'(master_granted), 64'(3'b001));
        check("async reset HWDATA", 64'(HWDATA), 64'(32'hD000_0000));
        check("async reset HADDR",  64'(HADDR),  64'(32'hA000_0000));
        check("async reset HSEL",   64'(HSEL),   64'(1'b0));
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Single-master instance never moves its grant.
        for (int n = 0; n < 4; n++) begin
            @(negedge HCLK);
            s_hsel = n[0];
            #1;
            check($sformatf("m1 c%0d grant", n), 64'(s_grant), 64'(1'b1));
            check($sformatf("m1 c%0d HTRANS", n), 64'(s_HTRANS),
                  64'(n[0] ? 2'b10 : 2'b00));
            check($sformatf("m1 c%0d HADDR", n), 64'(s_HADDR), 64'(32'h5555_0000));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
